dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate data cache with its controller.
- Sits between the MEM stage and data memory.
- Produces the `hit` pipeline-advance signal that the IF/ID, ID/EX, EX/MEM and MEM/WB registers use as their load enable.
- When `hit` is low, every pipeline register holds its contents while this block services a miss or a write-through to memory.

Parameters:
- INDEX_BITS, 4: log2 of the number of lines. Default gives 16 lines, one 64-bit word per line.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  MEM-stage load request.
- MemWrite  input  1  MEM-stage store request.
- Address  input  ADDR_W  byte address. Bits [2:0] are ignored (word access).
- WriteData  input  DATA_W  store data.
- ReadData  output  DATA_W  load data.
- hit  output  1  1 = pipeline may advance; 0 = stall.
- mem_req  output  1  memory request, held until mem_ready.
- mem_we  output  1  1 = write, 0 = read. Valid only while mem_req = 1.
- mem_addr  output  ADDR_W  word-aligned memory address (bits [2:0] = 0).
- mem_wdata  output  DATA_W  memory write data.
- mem_ready  input  1  memory completion, a one-cycle pulse. On a read, mem_rdata is valid in the same cycle.
- mem_rdata  input  DATA_W  memory read data.
- miss_count  output  32  count of read misses; saturates at 0xFFFFFFFF.

Behaviour:
- Address decode:
  - index = Address[INDEX_BITS+2:3]
  - tag = Address[ADDR_W-1:INDEX_BITS+3]
  - Each line holds a valid bit, a tag and a data word.
- Request latching: on leaving IDLE, Address, WriteData and the request type are captured in internal registers. Memory-side outputs are driven only from these captured values.
- State IDLE:
  - No request: hit = 1, mem_req = 0.
  - MemRead with valid and tag match: hit = 1 combinationally in the same cycle; ReadData = line data (zero-latency hit).
  - MemRead miss: hit = 0; miss_count increments; next state FETCH.
  - MemWrite (hit or miss): hit = 0; next state WRITE.
  - MemRead and MemWrite both high: treated as a write; no read is performed.
- State FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = captured word address; hit = 0.
  - On mem_ready: line is written (valid = 1, tag, data = mem_rdata); ReadData register = mem_rdata; next state DONE.
- State WRITE:
  - mem_req = 1, mem_we = 1, mem_wdata = captured WriteData; hit = 0.
  - On mem_ready: if the line is valid with a matching tag, its data is updated; otherwise the cache is unchanged (no allocate). Next state DONE.
- State DONE:
  - Lasts exactly one cycle; hit = 1; mem_req = 0.
  - After a FETCH, ReadData = captured fill data.
  - Next state IDLE unconditionally. The request still present in DONE is the one being retired, so it is not re-issued.
- ReadData: outside a read hit or DONE-after-FETCH it holds its last value.
- Miss latency: 1 request cycle plus memory latency plus 1 DONE cycle.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ready cycle inclusive.
- mem_ready outside FETCH/WRITE is ignored.
- Reset (synchronous, any state, including mid-FETCH/WRITE):
  - Takes effect at the next rising edge.
  - State = IDLE; all valid bits = 0; ReadData = 0; miss_count = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - hit = 1 if no request is present after reset.
  - An outstanding memory transaction is abandoned; a mem_ready arriving later is ignored.
- miss_count counts read misses only and stops at 0xFFFFFFFF.

Test Plan:
- Idle/spurious ready: reset, no requests, pulse mem_ready -> hit = 1 every cycle; mem_req = 0; cache and miss_count unchanged.
- Cold read miss then hit:
  - MemRead Address = 0x40; memory returns 0xDEADBEEF with mem_ready 4 cycles after mem_req -> hit = 0 for 5 cycles; mem_addr = 0x40, mem_we = 0; in DONE hit = 1 and ReadData = 0xDEADBEEF; miss_count = 1.
  - Repeat read of 0x40 -> hit = 1 in the same cycle, no mem_req.
- Conflict eviction: after caching 0x40, read 0x840 (same index 8) -> miss, fill; re-read 0x40 -> miss again; miss_count = 3.
- Write-through hit: with 0x40 cached, MemWrite 0x40 data 0x1234 -> mem_req = 1, mem_we = 1, mem_wdata = 0x1234 until mem_ready; then DONE; read 0x40 -> same-cycle hit returning 0x1234, no mem_req.
- No-write-allocate: MemWrite 0x80 (line invalid) -> memory write issued; a subsequent read of 0x80 misses and miss_count increments.
- Reset mid-FETCH: assert reset 2 cycles into FETCH for 0x40 -> mem_req = 0 after the edge; a late mem_ready is ignored; read 0x40 -> miss; miss_count restarts at 1.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache. Drives the
// pipeline-advance signal `hit` and a single-outstanding memory port.
module dcache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 3;
  localparam int WORD_W = ADDR_W - 3;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t state, nextState;

  logic [LINES-1:0]  lineValid;
  logic [TAG_W-1:0]  lineTag  [LINES];
  logic [DATA_W-1:0] lineData [LINES];

  logic [WORD_W-1:0]     reqWord;
  logic [DATA_W-1:0]     reqData;
  logic [DATA_W-1:0]     readDataReg;
  logic [INDEX_BITS-1:0] inIndex, reqIndex;
  logic [TAG_W-1:0]      inTag, reqTag;
  logic                  readReq, writeReq, lookupHit, reqLineHit;
  logic                  unusedAddrBits;

  assign unusedAddrBits = ^Address[2:0];

  assign inIndex  = Address[INDEX_BITS+2:3];
  assign inTag    = Address[ADDR_W-1:INDEX_BITS+3];
  assign reqIndex = reqWord[INDEX_BITS-1:0];
  assign reqTag   = reqWord[WORD_W-1:INDEX_BITS];

  // A simultaneous load and store is serviced as a store only.
  assign writeReq = MemWrite;
  assign readReq  = MemRead & ~MemWrite;

  assign lookupHit  = lineValid[inIndex] && (lineTag[inIndex] == inTag);
  assign reqLineHit = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);

  // Memory handshake: mem_req rises with a captured request and stays high,
  // with mem_we/mem_addr/mem_wdata frozen, through the cycle mem_ready is seen.
  assign mem_req   = (state == FETCH) || (state == WRITE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = {reqWord, 3'b000};
  assign mem_wdata = reqData;

  always_comb begin
    nextState = state;
    hit       = 1'b1;
    ReadData  = readDataReg;
    case (state)
      IDLE: begin
        if (writeReq) begin
          hit       = 1'b0;
          nextState = WRITE;
        end else if (readReq) begin
          if (lookupHit) begin
            ReadData = lineData[inIndex];
          end else begin
            hit       = 1'b0;
            nextState = FETCH;
          end
        end
      end
      FETCH: begin
        hit = 1'b0;
        if (mem_ready) nextState = DONE;
      end
      WRITE: begin
        hit = 1'b0;
        if (mem_ready) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lineValid   <= '0;
      reqWord     <= '0;
      reqData     <= '0;
      readDataReg <= '0;
      miss_count  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && nextState != IDLE) begin
        reqWord <= Address[ADDR_W-1:3];
        reqData <= WriteData;
      end
      if (state == IDLE && readReq && lookupHit) readDataReg <= lineData[inIndex];
      if (state == IDLE && readReq && !lookupHit && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
      if (state == FETCH && mem_ready) begin
        lineValid[reqIndex] <= 1'b1;
        readDataReg         <= mem_rdata;
      end
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FETCH && mem_ready) begin
        lineTag[reqIndex]  <= reqTag;
        lineData[reqIndex] <= mem_rdata;
      end else if (state == WRITE && mem_ready && reqLineHit) begin
        lineData[reqIndex] <= reqData;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, randomized transactions
// against a transaction-level cache model, and reset-during-fetch sequence.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [63:0] Address, WriteData;
  logic [63:0] ReadData;
  logic        hit;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [31:0] miss_count;

  dcache_controller dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Backing memory and transaction-level cache model.
  logic [63:0] memArr [logic [63:0]];
  bit          mValid [16];
  logic [63:0] mTag   [16];
  logic [63:0] mData  [16];
  logic [31:0] mMiss;
  logic [63:0] mLastRd;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
    bit          expHit;
    logic [63:0] expData;
    logic [31:0] expMiss;
  } vec_t;

  vec_t vecs [12];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [63:0] memGet(logic [63:0] wa);
    if (memArr.exists(wa)) return memArr[wa];
    return wa ^ 64'hFEED_0000_0000_FEED;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    mMiss   = 0;
    mLastRd = 0;
  endfunction

  function automatic void predict(input bit rd, input bit wr, input logic [63:0] addr,
                                  output bit eHit, output logic [63:0] eData,
                                  output logic [31:0] eMiss);
    logic [63:0] wa;
    int idx;
    wa  = addr & ~64'h7;
    idx = int'((wa >> 3) % 16);
    if (wr || !rd) begin
      eHit = 1'b0; eData = mLastRd; eMiss = mMiss;
    end else if (mValid[idx] && mTag[idx] == (wa >> 7)) begin
      eHit = 1'b1; eData = mData[idx]; eMiss = mMiss;
    end else begin
      eHit = 1'b0; eData = memGet(wa); eMiss = mMiss + 1;
    end
  endfunction

  function automatic void modelApply(bit rd, bit wr, logic [63:0] wa,
                                     logic [63:0] wdata, logic [63:0] fill);
    int idx;
    bit lineHit;
    idx     = int'((wa >> 3) % 16);
    lineHit = mValid[idx] && mTag[idx] == (wa >> 7);
    if (wr) begin
      if (lineHit) mData[idx] = wdata;
    end else if (rd) begin
      if (!lineHit) begin
        mValid[idx] = 1'b1; mTag[idx] = wa >> 7; mData[idx] = fill;
        mMiss = mMiss + 1;
      end
      mLastRd = mData[idx];
    end
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
  endtask

  task automatic idleCycle(input bit pulseReady);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ready = pulseReady;
    mem_rdata = {$urandom(), $urandom()};
    #1;
    chk("idle_hit", hit, 1'b1);
    chk("idle_mem_req", mem_req, 1'b0);
    chk("idle_miss_count", miss_count, mMiss);
    chk("idle_rdata", ReadData, mLastRd);
  endtask

  task automatic doTxn(input bit rd, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input int lat, input bit expHit,
                       input logic [63:0] expData, input logic [31:0] expMiss);
    logic [63:0] wa, fill;
    wa   = addr & ~64'h7;
    fill = memGet(wa);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
    mem_ready = 1'b0; mem_rdata = {$urandom(), $urandom()};
    #1;
    chk("req_hit", hit, expHit);
    if (expHit) begin
      chk("hit_rdata", ReadData, expData);
      chk("hit_mem_req", mem_req, 1'b0);
      chk("hit_miss_count", miss_count, expMiss);
    end else begin
      chk("req_mem_req", mem_req, 1'b0);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        mem_ready = (k == lat);
        mem_rdata = (k == lat && !wr) ? fill : {$urandom(), $urandom()};
        #1;
        chk("busy_mem_req", mem_req, 1'b1);
        chk("busy_mem_we", mem_we, wr);
        chk("busy_mem_addr", mem_addr, wa);
        chk("busy_hit", hit, 1'b0);
        if (wr) chk("busy_mem_wdata", mem_wdata, wdata);
      end
      if (wr) memArr[wa] = wdata;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("done_hit", hit, 1'b1);
      chk("done_mem_req", mem_req, 1'b0);
      chk("done_rdata", ReadData, expData);
      chk("done_miss_count", miss_count, expMiss);
    end
    modelApply(rd, wr, wa, wdata, fill);
  endtask

  initial begin
    logic [63:0] pool [6];
    logic [63:0] addr, data;
    bit          eHit, rd, wr;
    logic [63:0] eData;
    logic [31:0] eMiss;
    int          op;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    memArr[64'h40]  = 64'hDEAD_BEEF;
    memArr[64'h840] = 64'h0BAD_F00D;
    memArr[64'h80]  = 64'h8080_8080;

    vecs[0]  = '{1'b1, 1'b0, 64'h40,  64'h0,    4, 1'b0, 64'hDEAD_BEEF, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 64'h40,  64'h0,    1, 1'b1, 64'hDEAD_BEEF, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 64'h840, 64'h0,    2, 1'b0, 64'h0BAD_F00D, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 64'h40,  64'h0,    1, 1'b0, 64'hDEAD_BEEF, 32'd3};
    vecs[4]  = '{1'b0, 1'b1, 64'h40,  64'h1234, 3, 1'b0, 64'hDEAD_BEEF, 32'd3};
    vecs[5]  = '{1'b1, 1'b0, 64'h40,  64'h0,    1, 1'b1, 64'h1234,      32'd3};
    vecs[6]  = '{1'b0, 1'b1, 64'h80,  64'h5555, 2, 1'b0, 64'h1234,      32'd3};
    vecs[7]  = '{1'b1, 1'b0, 64'h80,  64'h0,    2, 1'b0, 64'h5555,      32'd4};
    vecs[8]  = '{1'b1, 1'b0, 64'h80,  64'h0,    1, 1'b1, 64'h5555,      32'd4};
    vecs[9]  = '{1'b1, 1'b1, 64'h48,  64'h77,   1, 1'b0, 64'h5555,      32'd4};
    vecs[10] = '{1'b1, 1'b0, 64'h48,  64'h0,    1, 1'b0, 64'h77,        32'd5};
    vecs[11] = '{1'b1, 1'b0, 64'h4F,  64'h0,    1, 1'b1, 64'h77,        32'd5};

    doReset();
    #1;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    for (int i = 0; i < 4; i++) idleCycle(i[0]);

    for (int i = 0; i < 12; i++)
      doTxn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
            vecs[i].expHit, vecs[i].expData, vecs[i].expMiss);

    pool = '{64'h40, 64'h840, 64'h80, 64'h48, 64'h1040, 64'hC0};
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        idleCycle(1'($urandom_range(0, 1)));
      end else begin
        addr = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 7));
        data = {$urandom(), $urandom()};
        rd   = (op != 2);
        wr   = (op >= 2);
        predict(rd, wr, addr, eHit, eData, eMiss);
        doTxn(rd, wr, addr, data, $urandom_range(1, 4), eHit, eData, eMiss);
      end
    end

    // Reset lands on the second FETCH cycle; the late ready must be dropped.
    doReset();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Address = 64'h40; mem_ready = 1'b0;
    #1;
    chk("mf_req_hit", hit, 1'b0);
    @(negedge clk);
    #1;
    chk("mf_fetch1_mem_req", mem_req, 1'b1);
    chk("mf_fetch1_miss_count", miss_count, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mf_fetch2_mem_req", mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0;
    #1;
    chk("mf_rst_mem_req", mem_req, 1'b0);
    chk("mf_rst_hit", hit, 1'b1);
    chk("mf_rst_miss_count", miss_count, 32'd0);
    chk("mf_rst_rdata", ReadData, 64'h0);
    chk("mf_rst_mem_addr", mem_addr, 64'h0);
    modelClear();
    idleCycle(1'b1);
    idleCycle(1'b0);
    predict(1'b1, 1'b0, 64'h40, eHit, eData, eMiss);
    doTxn(1'b1, 1'b0, 64'h40, 64'h0, 2, eHit, eData, eMiss);
    chk("mf_reread_miss_count", miss_count, 32'd1);
    idleCycle(1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
